// File: rtl/apb_cmd_queue_if.sv
// Client command/response handshakes plus the request side of the APB system wrapper.
// The queue uses the slave view; the client and APB master side use the master view.
interface apb_cmd_queue_if #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAIN_ADDR_WIDTH = 32,
    parameter int unsigned DEPTH           = 4
);
    localparam int unsigned DATA_BYTE_NUM = DATA_WIDTH / 8;
    localparam int unsigned LVL_W         = $clog2(DEPTH) + 1;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [MAIN_ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]      cmd_wdata;
    logic [DATA_BYTE_NUM-1:0]   cmd_strb;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_WIDTH-1:0]      rsp_rdata;
    logic                       rsp_write;
    logic                       rsp_err;

    logic [LVL_W-1:0]           level;

    logic                       transfer;
    logic [MAIN_ADDR_WIDTH-1:0] ADDR;
    logic [DATA_WIDTH-1:0]      WDATA;
    logic                       WRITE;
    logic [DATA_BYTE_NUM-1:0]   STRB;
    logic                       READY;
    logic [DATA_WIDTH-1:0]      RDATA;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, READY, RDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err, level,
        output transfer, ADDR, WDATA, WRITE, STRB
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, READY, RDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err, level,
        input  transfer, ADDR, WDATA, WRITE, STRB
    );
endinterface

// File: rtl/apb_cmd_queue.sv
// Command FIFO in front of the APB system wrapper: issues queued commands one at a time, in order,
// and returns one held response per command. APB_CMDQ_TIMEOUT_EN adds a READY watchdog.
module apb_cmd_queue #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAIN_ADDR_WIDTH = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input logic            PCLK,
    input logic            PRESET_n,
    apb_cmd_queue_if.slave bus
);
    localparam int unsigned DATA_BYTE_NUM = DATA_WIDTH / 8;
    localparam int unsigned LVL_W         = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W         = $clog2(DEPTH);
    localparam int unsigned ENTRY_W       = 1 + MAIN_ADDR_WIDTH + DATA_WIDTH + DATA_BYTE_NUM;

    typedef enum logic [1:0] {StIdle, StIssue, StRsp} state_e;

    state_e                state_q;
    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  transfer_q;
    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic full;
    logic push;
    logic pop;
    logic done;
    logic timeout;

    assign full = (level_q == LVL_W'(DEPTH));
    assign push = bus.cmd_valid && !full;
    assign done = (state_q == StIssue) && bus.READY;
    assign pop  = done || timeout;

`ifdef APB_CMDQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // Held at zero outside ISSUE, so every entry into ISSUE starts a fresh count.
    assign timeout = (state_q == StIssue) && !bus.READY && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            wd_q <= '0;
        end else if (state_q != StIssue) begin
            wd_q <= '0;
        end else if (!bus.READY) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb};
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q     <= StIdle;
            transfer_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (level_q != '0) begin
                        state_q    <= StIssue;
                        transfer_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (pop) begin
                        state_q     <= StRsp;
                        transfer_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= bus.WRITE;
                        // A completion arriving on the timeout cycle still counts as success.
                        rsp_err_q   <= !done;
                        rsp_rdata_q <= (done && !bus.WRITE) ? bus.RDATA : '0;
                    end
                end
                StRsp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        if (level_q != '0) begin
                            state_q    <= StIssue;
                            transfer_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.level     = level_q;
    assign bus.transfer  = transfer_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign {bus.WRITE, bus.ADDR, bus.WDATA, bus.STRB} =
        (level_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_apb_cmd_queue.sv
// Self-checking bench for apb_cmd_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_cmd_queue;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 16;
    localparam int unsigned BN    = DW / 8;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BN-1:0] s;
    } cmd_t;

    typedef struct packed {
        logic          w;
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    logic PCLK = 1'b0;
    logic PRESET_n = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_cmd_queue_if #(.DATA_WIDTH(DW), .MAIN_ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    apb_cmd_queue #(
        .DATA_WIDTH(DW),
        .MAIN_ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESET_n(PRESET_n),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    cmd_t q_cmd[$];
    rsp_t q_rsp[$];
    rsp_t seen[$];
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] slave_mem [8];
    logic [DW-1:0] junk = '0;
    bit   exp_xfer = 0;
    bit   pushed = 0;
    bit   rnd_ready = 0;
    bit   rnd_rsp = 0;
    int   wd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // APB master/slave stand-in: memory behind the wrapper, junk read data on writes.
    assign bus.RDATA = bus.WRITE ? junk : slave_mem[bus.ADDR[4:2]];

    always @(posedge PCLK) begin
        if (bus.transfer && bus.READY && bus.WRITE) begin
            for (int b = 0; b < BN; b++) begin
                if (bus.STRB[b]) slave_mem[bus.ADDR[4:2]][8*b +: 8] = bus.WDATA[8*b +: 8];
            end
        end
        #1;
        junk = $urandom;
        if (rnd_ready) bus.READY = ($urandom_range(0, 2) == 0);
        if (rnd_rsp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference model: commands in flight, pending responses, and when a transfer must be shown.
    always @(negedge PCLK) begin
        int   cnt;
        cmd_t head;
        cmd_t c;
        rsp_t r;
        bit   xfer_now;
        bit   fin;
        bit   tmo;
        bit   acc;
        bit   push;
        if (!PRESET_n) begin
            q_cmd.delete();
            q_rsp.delete();
            exp_xfer = 0;
            wd = 0;
            pushed = 0;
        end else begin
            cnt = q_cmd.size();
            head = (cnt != 0) ? q_cmd[0] : '0;
            chk("level", 64'(bus.level), 64'(cnt));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(cnt < DEPTH));
            chk("transfer", 64'(bus.transfer), 64'(exp_xfer));
            chk("ADDR", 64'(bus.ADDR), 64'(head.a));
            chk("WDATA", 64'(bus.WDATA), 64'(head.d));
            chk("WRITE", 64'(bus.WRITE), 64'(head.w));
            chk("STRB", 64'(bus.STRB), 64'(head.s));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(q_rsp.size() != 0));
            if (q_rsp.size() != 0) begin
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(q_rsp[0].d));
                chk("rsp_write", 64'(bus.rsp_write), 64'(q_rsp[0].w));
                chk("rsp_err", 64'(bus.rsp_err), 64'(q_rsp[0].e));
            end else begin
                chk("rsp_err_idle", 64'(bus.rsp_err), 64'd0);
            end

            xfer_now = exp_xfer;
            fin = xfer_now && bus.READY;
            tmo = 0;
`ifdef APB_CMDQ_TIMEOUT_EN
            tmo = xfer_now && !bus.READY && (wd == TO - 1);
`endif
            acc = (q_rsp.size() != 0) && bus.rsp_ready;
            push = bus.cmd_valid && (cnt < DEPTH);

            if (acc) begin
                seen.push_back(rsp_t'({bus.rsp_write, bus.rsp_rdata, bus.rsp_err}));
                void'(q_rsp.pop_front());
            end
            // Issue whenever work is queued, no response is outstanding and none just completed.
            exp_xfer = (cnt > 0) && !(fin || tmo) && (q_rsp.size() == 0);
            if (fin || tmo) begin
                c = q_cmd.pop_front();
                r.w = c.w;
                r.e = tmo;
                r.d = (tmo || c.w) ? '0 : ref_mem[c.a[4:2]];
                if (fin && c.w) begin
                    for (int b = 0; b < BN; b++) begin
                        if (c.s[b]) ref_mem[c.a[4:2]][8*b +: 8] = c.d[8*b +: 8];
                    end
                end
                q_rsp.push_back(r);
            end
            wd = (xfer_now && !bus.READY && !tmo) ? wd + 1 : 0;
            if (push) begin
                c = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb};
                q_cmd.push_back(c);
            end
            pushed = push;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BN-1:0] s);
        bit ok;
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        for (int i = 0; i < 200; i++) begin
            @(posedge PCLK);
            if (pushed) begin
                ok = 1;
                break;
            end
        end
        #1;
        bus.cmd_valid = 1'b0;
        chk("push_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (seen.size() >= n) begin
                ok = 1;
                break;
            end
        end
        chk("rsp_arrived", 64'(ok), 64'd1);
        tick(1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PCLK);
            if (q_cmd.size() == 0 && q_rsp.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 64'(ok), 64'd1);
        tick(1);
    endtask

    initial begin
        int base;
        int hi;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.READY     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i]   = '0;
            slave_mem[i] = '0;
        end
        tick(3);
        PRESET_n = 1'b1;
        @(negedge PCLK);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_transfer", 64'(bus.transfer), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_addr", 64'(bus.ADDR), 64'd0);
        tick(1);

        // Single write: one-cycle issue latency, transfer held until READY.
        bus.rsp_ready = 1'b1;
        push_cmd(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
        @(negedge PCLK);
        chk("t1_no_xfer_yet", 64'(bus.transfer), 64'd0);
        chk("t1_level", 64'(bus.level), 64'd1);
        @(negedge PCLK);
        chk("t1_xfer", 64'(bus.transfer), 64'd1);
        chk("t1_addr", 64'(bus.ADDR), 64'h4);
        chk("t1_write", 64'(bus.WRITE), 64'd1);
        repeat (3) @(negedge PCLK);
        chk("t1_xfer_held", 64'(bus.transfer), 64'd1);
        tick(1);
        bus.READY = 1'b1;
        wait_rsp(1);
        chk("t1_rsp_write", 64'(seen[0].w), 64'd1);
        chk("t1_rsp_rdata", 64'(seen[0].d), 64'd0);

        // Write then read back through the slave memory.
        push_cmd(1'b1, 32'h8, 32'h1234_5678, 4'hF);
        push_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        wait_rsp(3);
        chk("t2_rd_data", 64'(seen[2].d), 64'h1234_5678);
        chk("t2_rd_write", 64'(seen[2].w), 64'd0);
        drain();

        // Backpressure: queue fills to DEPTH with READY low, fifth command held off.
        bus.READY = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'(i * 4), 32'h0, 4'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h1C;
        bus.cmd_wdata = 32'hA5A5_0F0F;
        bus.cmd_strb  = 4'h3;
        tick(3);
        @(negedge PCLK);
        chk("t3_full_level", 64'(bus.level), 64'd4);
        chk("t3_full_ready", 64'(bus.cmd_ready), 64'd0);
        tick(1);
        bus.READY = 1'b1;
        tick(1);
        bus.READY = 1'b0;
        @(negedge PCLK);
        chk("t3_after_pop_level", 64'(bus.level), 64'd3);
        chk("t3_after_pop_ready", 64'(bus.cmd_ready), 64'd1);
        tick(1);
        bus.cmd_valid = 1'b0;
        bus.READY = 1'b1;
        drain();

        // Response held: no further issue while rsp_ready is low, queue fills meanwhile.
        bus.rsp_ready = 1'b0;
        push_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'(16 + i * 4), 32'($urandom), 4'hF);
        @(negedge PCLK);
        chk("t4_level", 64'(bus.level), 64'd4);
        chk("t4_no_xfer", 64'(bus.transfer), 64'd0);
        chk("t4_rsp_held", 64'(bus.rsp_valid), 64'd1);
        chk("t4_rsp_data", 64'(bus.rsp_rdata), 64'h1234_5678);
        tick(1);
        bus.rsp_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of an issue with three commands queued.
        bus.READY = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 32'(i * 4), 32'h0, 4'h0);
        tick(2);
        PRESET_n = 1'b0;
        #1;
        chk("t5_rst_xfer", 64'(bus.transfer), 64'd0);
        chk("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t5_rst_level", 64'(bus.level), 64'd0);
        chk("t5_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick(2);
        PRESET_n = 1'b1;
        bus.READY = 1'b1;
        base = seen.size();
        tick(10);
        chk("t5_no_rsp_after_rst", 64'(seen.size() - base), 64'd0);

`ifdef APB_CMDQ_TIMEOUT_EN
        // READY stuck low: watchdog ends the transfer after TIMEOUT_CYCLES issue cycles.
        bus.READY = 1'b0;
        base = seen.size();
        push_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        push_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (bus.transfer) hi++;
            else if (hi > 0) break;
        end
        chk("t6_timeout_cycles", 64'(hi), 64'(TO));
        tick(1);
        bus.READY = 1'b1;
        wait_rsp(base + 2);
        chk("t6_err", 64'(seen[base].e), 64'd1);
        chk("t6_err_rdata", 64'(seen[base].d), 64'd0);
        chk("t6_next_ok", 64'(seen[base + 1].e), 64'd0);
        drain();
`else
        hi = 0;
        base = 0;
`endif

        // Randomized traffic.
        rnd_ready = 1;
        rnd_rsp = 1;
        for (int n = 0; n < 600; n++) begin
            if (!bus.cmd_valid || pushed) begin
                bus.cmd_valid = ($urandom_range(0, 1) == 1);
                bus.cmd_write = ($urandom_range(0, 1) == 1);
                bus.cmd_addr  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
                bus.cmd_wdata = $urandom;
                bus.cmd_strb  = 4'($urandom_range(0, 15));
            end
            tick(1);
        end
        bus.cmd_valid = 1'b0;
        rnd_ready = 0;
        rnd_rsp = 0;
        bus.READY = 1'b1;
        bus.rsp_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_cmd_queue.md
Name: apb_cmd_queue

Overview:
- Buffered request front-end directly upstream of the APB system wrapper. It drives the wrapper's higher-logic side: transfer, ADDR, WDATA, WRITE and STRB in, READY and RDATA out.
- Accepts commands from a CPU or DMA-style client over a valid/ready interface and queues them in a FIFO.
- Issues the commands one at a time to the APB master, in order.
- Returns one response per command over a second valid/ready interface, holding it until the client accepts it.

Parameters:
- DATA_WIDTH, 32, data width for WDATA/RDATA.
- MAIN_ADDR_WIDTH, 32, address width.
- DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 16, watchdog limit; used only with APB_CMDQ_TIMEOUT_EN.
- Derived: DATA_BYTE_NUM = DATA_WIDTH/8; LVL_W = $clog2(DEPTH)+1.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESET_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  client command valid.
- cmd_ready  out  1  queue can accept a command (= !full).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  MAIN_ADDR_WIDTH  command address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_BYTE_NUM  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  client accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_write  out  1  echo of the command's write bit.
- rsp_err  out  1  timeout flag; tied 0 without the macro.
- level  out  LVL_W  FIFO occupancy, 0..DEPTH.
- transfer  out  1  request to the APB master.
- ADDR  out  MAIN_ADDR_WIDTH  to the master.
- WDATA  out  DATA_WIDTH  to the master.
- WRITE  out  1  to the master.
- STRB  out  DATA_BYTE_NUM  to the master.
- READY  in  1  transfer completion from the master.
- RDATA  in  DATA_WIDTH  read data from the master.

Behaviour:
- Reset (asynchronous, PRESET_n=0; takes effect immediately, mid-transfer included):
  - FIFO emptied; pointers and level cleared.
  - State goes to IDLE.
  - transfer, rsp_valid, rsp_err, rsp_write = 0; rsp_rdata = 0.
  - cmd_ready = 1 after reset.
  - ADDR/WDATA/WRITE/STRB = 0 while the FIFO is empty; otherwise they reflect the FIFO head.
- FIFO:
  - Push when cmd_valid && cmd_ready. Pop on transfer completion.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - level updates by +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
  - cmd_ready depends only on full: a push is refused while full even if a pop happens that cycle (no pass-through).
- State machine, IDLE -> ISSUE -> RSP:
  - IDLE: transfer=0. Goes to ISSUE when level != 0. Earliest issue is the cycle after the push (one-cycle latency into an empty queue).
  - ISSUE:
    - transfer=1; ADDR/WDATA/WRITE/STRB driven from the FIFO head and held stable until READY.
    - On READY=1: capture rsp_rdata = WRITE ? 0 : RDATA and rsp_write = WRITE; set rsp_valid=1, pop the head, go to RSP.
  - RSP:
    - transfer=0 (at least one idle cycle between APB transfers).
    - On rsp_valid && rsp_ready: clear rsp_valid, then go to ISSUE if level != 0 after the pop, else IDLE.
    - If rsp_ready is held low the response is held indefinitely; the FIFO keeps accepting pushes until full.
- READY is ignored outside ISSUE.
- Ordering: responses come back strictly in command order, exactly one per command.

Optional Feature:
- Macro: APB_CMDQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to ISSUE and increments each ISSUE cycle while READY=0.
  - When it reaches TIMEOUT_CYCLES: drop transfer, pop the head, set rsp_valid=1 with rsp_err=1 and rsp_rdata=0, go to RSP.
  - If READY=1 arrives in the same cycle as the timeout, the normal completion wins and rsp_err=0.
  - rsp_err clears on response acceptance.
- Undefined: no counter; ISSUE waits forever for READY; rsp_err is constant 0.

Test Plan:
- Reset, then push write addr=0x4, wdata=0xDEADBEEF, strb=4'hF:
  - transfer rises the cycle after the push with ADDR=0x4, WRITE=1 and stays high until READY.
  - One rsp with rsp_write=1, rsp_rdata=0.
- Write 0x12345678 to addr 0x8, then read addr 0x8 through the wrapper with slave0 selected -> second rsp_rdata=0x12345678, rsp_write=0.
- Push 5 commands with DEPTH=4 and READY held low:
  - cmd_ready=0 once level=4; the 5th command is held off.
  - After READY completes one transfer, level=3 and cmd_ready=1.
- Hold rsp_ready=0 after the first completion -> transfer stays 0, rsp_valid and data held, FIFO fills to 4. Release rsp_ready -> the remaining commands issue in order.
- Assert PRESET_n=0 mid-ISSUE with level=3 -> transfer, rsp_valid, level = 0 immediately, and no response emitted after release.
- With APB_CMDQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, READY stuck low -> after 16 ISSUE cycles transfer drops, rsp_err=1, rsp_rdata=0, and the next command issues.
